// File: rtl/serial_pkg.sv
// Shared constants, TX state encoding and timeout sizing for the serial work sender.
package serial_pkg;

  localparam int WORK_BYTES  = 64;
  localparam int NONCE_BYTES = 4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_WAIT_HI,
    TX_WAIT_LO
  } tx_state_t;

  // One UART byte is 10 bit times (start, 8 data, stop).
  function automatic int unsigned rx_timeout_cycles(input int unsigned clock_hz,
                                                    input int unsigned baud,
                                                    input int unsigned bytes);
    return (clock_hz / baud) * 10 * bytes;
  endfunction

endpackage

// File: rtl/nonce_assembler.sv
// Packs four received UART bytes (first byte -> [31:24]) into a nonce; nonce_valid one cycle after the 4th byte.
// Never blocks the receiver; SERIAL_RX_TIMEOUT_EN drops a partial nonce after an idle gap.
module nonce_assembler
  import serial_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 17360
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_ready,
  input  logic [7:0]  rx_byte,
  output logic        nonce_valid,
  output logic [31:0] nonce
);

  logic [23:0] nonce_sr;
  logic [1:0]  rx_cnt;
  logic        rx_expire;

`ifdef SERIAL_RX_TIMEOUT_EN
  logic [31:0] gap_timer;

  // Timer only runs while a nonce is partially assembled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_timer <= '0;
    end else if (rx_ready || rx_expire || rx_cnt == 2'd0) begin
      gap_timer <= '0;
    end else begin
      gap_timer <= gap_timer + 32'd1;
    end
  end

  assign rx_expire = (rx_cnt != 2'd0) && (gap_timer == TIMEOUT_CYCLES - 1);
`else
  assign rx_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nonce_sr    <= '0;
      rx_cnt      <= '0;
      nonce       <= '0;
      nonce_valid <= 1'b0;
    end else begin
      nonce_valid <= 1'b0;
      if (rx_expire) begin
        // A byte landing on the expiry cycle starts a fresh nonce.
        nonce_sr <= rx_ready ? {16'h0, rx_byte} : 24'h0;
        rx_cnt   <= rx_ready ? 2'd1 : 2'd0;
      end else if (rx_ready) begin
        nonce_sr <= {nonce_sr[15:0], rx_byte};
        rx_cnt   <= rx_cnt + 2'd1;
        if (rx_cnt == 2'(NONCE_BYTES - 1)) begin
          nonce       <= {nonce_sr, rx_byte};
          nonce_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/serial_work_sender.sv
// Frames a 512-bit work unit {midstate,data2} MSB-first into 64 UART bytes and assembles 4-byte nonce replies.
// TX start strobe one cycle after SEND sees the UART idle; work is refused while a frame is in flight; RX never stalls.
// Optional RX inter-byte timeout enabled by defining SERIAL_RX_TIMEOUT_EN.
module serial_work_sender
  import serial_pkg::*;
#(
  parameter int unsigned CLOCK         = 25000000,
  parameter int unsigned BAUD          = 57600,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         work_valid,
  output logic         work_ready,
  input  logic [255:0] midstate,
  input  logic [255:0] data2,
  output logic         uart_tx_start,
  output logic [7:0]   uart_tx_byte,
  input  logic         uart_tx_busy,
  input  logic         uart_rx_ready,
  input  logic [7:0]   uart_rx_byte,
  output logic         nonce_valid,
  output logic [31:0]  nonce,
  output logic         tx_busy
);

  localparam int unsigned RX_TIMEOUT_CYCLES = rx_timeout_cycles(CLOCK, BAUD, TIMEOUT_BYTES);

  tx_state_t    state_q, state_d;
  logic [511:0] shift_q;
  logic [6:0]   byte_cnt_q;
  logic         accept;
  logic         send;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    send    = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (work_valid) begin
          accept  = 1'b1;
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (!uart_tx_busy) begin
          send    = 1'b1;
          state_d = TX_WAIT_HI;
        end
      end
      TX_WAIT_HI: begin
        if (uart_tx_busy) state_d = TX_WAIT_LO;
      end
      TX_WAIT_LO: begin
        if (!uart_tx_busy) begin
          state_d = (byte_cnt_q == 7'(WORK_BYTES)) ? TX_IDLE : TX_SEND;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign work_ready = (state_q == TX_IDLE);
  assign tx_busy    = !work_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= TX_IDLE;
      shift_q       <= '0;
      byte_cnt_q    <= '0;
      uart_tx_start <= 1'b0;
      uart_tx_byte  <= '0;
    end else begin
      state_q       <= state_d;
      uart_tx_start <= send;
      if (accept) begin
        shift_q    <= {midstate, data2};
        byte_cnt_q <= '0;
      end else if (send) begin
        uart_tx_byte <= shift_q[511:504];
        shift_q      <= {shift_q[503:0], 8'h00};
        byte_cnt_q   <= byte_cnt_q + 7'd1;
      end
    end
  end

  nonce_assembler #(
    .TIMEOUT_CYCLES (RX_TIMEOUT_CYCLES)
  ) u_nonce_assembler (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_ready    (uart_rx_ready),
    .rx_byte     (uart_rx_byte),
    .nonce_valid (nonce_valid),
    .nonce       (nonce)
  );

endmodule

// File: tb/tb_serial_work_sender.sv
// Scoreboard bench for serial_work_sender: UART TX model, random work/nonce stimulus, reset and timeout scenarios.
module tb_serial_work_sender;

  localparam int RX_TIMEOUT = (25000000 / 57600) * 10 * 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         work_valid = 1'b0;
  logic         work_ready;
  logic [255:0] midstate = '0;
  logic [255:0] data2 = '0;
  logic         uart_tx_start;
  logic [7:0]   uart_tx_byte;
  logic         uart_tx_busy = 1'b0;
  logic         uart_rx_ready = 1'b0;
  logic [7:0]   uart_rx_byte = '0;
  logic         nonce_valid;
  logic [31:0]  nonce;
  logic         tx_busy;

  serial_work_sender dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .work_valid    (work_valid),
    .work_ready    (work_ready),
    .midstate      (midstate),
    .data2         (data2),
    .uart_tx_start (uart_tx_start),
    .uart_tx_byte  (uart_tx_byte),
    .uart_tx_busy  (uart_tx_busy),
    .uart_rx_ready (uart_rx_ready),
    .uart_rx_byte  (uart_rx_byte),
    .nonce_valid   (nonce_valid),
    .nonce         (nonce),
    .tx_busy       (tx_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  tx_exp[$];
  logic [31:0] rx_exp[$];
  logic [7:0]  rx_pend[$];
  logic [31:0] last_nonce = '0;
  int          last_rx_cyc = 0;

  int busy_cnt = 0;
  int tx_popped = 0;
  int acc_cyc = 0;
  bit last_sent = 0;
  bit chk_ready_pending = 0;
  bit first_pending = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // UART TX model plus scoreboard monitor; everything sampled on the falling edge.
  always @(negedge clk) begin
    logic [511:0] w;
    if (!rst_n) begin
      busy_cnt          = 0;
      uart_tx_busy      = 1'b0;
      last_sent         = 0;
      chk_ready_pending = 0;
      first_pending     = 0;
    end else begin
      if (chk_ready_pending) begin
        check("ready_after_frame", work_ready, 1);
        chk_ready_pending = 0;
      end
      if (work_valid && work_ready) begin
        w = {midstate, data2};
        for (int i = 0; i < 64; i++) tx_exp.push_back(w[511-8*i -: 8]);
        acc_cyc       = cyc;
        first_pending = 1;
      end
      if (uart_tx_start) begin
        check("ready_low_in_frame", work_ready, 0);
        check("tx_busy_in_frame", tx_busy, 1);
        if (first_pending) begin
          check("start_latency", (cyc - acc_cyc) <= 3, 1);
          first_pending = 0;
        end
        if (tx_exp.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_tx: actual=%0h required=none", uart_tx_byte);
        end else begin
          check("tx_byte", uart_tx_byte, tx_exp.pop_front());
          tx_popped++;
          last_sent = (tx_exp.size() == 0);
        end
        busy_cnt = 10;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0 && last_sent) begin
          check("ready_at_busy_fall", work_ready, 0);
          chk_ready_pending = 1;
          last_sent         = 0;
        end
      end
      uart_tx_busy = (busy_cnt != 0);
      if (nonce_valid) begin
        if (rx_exp.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_nonce: actual=%0h required=none", nonce);
        end else begin
          check("nonce", nonce, rx_exp.pop_front());
        end
      end
    end
  end

  task automatic send_work(input logic [255:0] ms, input logic [255:0] d2);
    int n = 0;
    midstate   = ms;
    data2      = d2;
    work_valid = 1'b1;
    @(negedge clk);
    while (!work_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: actual=no_accept required=accept");
    end
    tick();
    work_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(tx_exp.size() == 0 && work_ready && busy_cnt == 0 && !chk_ready_pending) && n < 5000) begin
      tick();
      n++;
    end
    check("frame_done_in_time", n < 5000, 1);
  endtask

  // Reference model: four bytes in arrival order form a nonce; a long gap drops a partial one.
  task automatic rx_byte(input logic [7:0] b, input int gap);
`ifdef SERIAL_RX_TIMEOUT_EN
    if (rx_pend.size() != 0 && (cyc - last_rx_cyc) >= RX_TIMEOUT) rx_pend.delete();
`endif
    rx_pend.push_back(b);
    last_rx_cyc = cyc;
    if (rx_pend.size() == 4) begin
      last_nonce = {rx_pend[0], rx_pend[1], rx_pend[2], rx_pend[3]};
      rx_exp.push_back(last_nonce);
      rx_pend.delete();
    end
    uart_rx_ready = 1'b1;
    uart_rx_byte  = b;
    tick();
    uart_rx_ready = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_work_ready"}, work_ready, 1);
    check({tag, "_tx_busy"}, tx_busy, 0);
    check({tag, "_tx_start"}, uart_tx_start, 0);
    check({tag, "_tx_byte"}, uart_tx_byte, 0);
    check({tag, "_nonce_valid"}, nonce_valid, 0);
    check({tag, "_nonce"}, nonce, 0);
  endtask

  logic [255:0] pat_ms, pat_d2;

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int base;
    logic [31:0] exp_to;
    for (int i = 0; i < 32; i++) begin
      pat_ms[255-8*i -: 8] = 8'(i);
      pat_d2[255-8*i -: 8] = 8'(i + 32);
    end

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // Counting-pattern frame with nonce bytes arriving mid-frame.
    fork
      send_work(pat_ms, pat_d2);
      begin
        repeat (40) tick();
        rx_byte(8'hDE, 3);
        rx_byte(8'hAD, 0);
        rx_byte(8'hBE, 7);
        rx_byte(8'hEF, 20);
        rx_byte(8'h01, 0);
        rx_byte(8'h02, 0);
        rx_byte(8'h03, 0);
        rx_byte(8'h04, 2);
      end
    join
    wait_idle();
    check("nonce_held", nonce, 32'h01020304);

    // work_valid held high with changing data across several frames.
    repeat (2200) begin
      work_valid = 1'b1;
      midstate   = rand256();
      data2      = rand256();
      tick();
    end
    work_valid = 1'b0;
    wait_idle();

    // Random nonce bytes with random gaps, including back-to-back strobes.
    for (int i = 0; i < 12; i++) rx_byte(8'($urandom), $urandom_range(0, 5));
    repeat (5) tick();

    // Reset in the middle of a frame.
    base = tx_popped;
    fork
      send_work(rand256(), rand256());
    join_none
    n = 0;
    while (tx_popped < base + 20 && n < 5000) begin
      tick();
      n++;
    end
    check("reach_byte_20", n < 5000, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    tx_exp.delete();
    rx_exp.delete();
    rx_pend.delete();
    last_nonce = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    send_work(pat_ms, pat_d2);
    wait_idle();

    // Partial nonce followed by a long silence.
    rx_byte(8'hAA, 0);
    rx_byte(8'hBB, 20000);
    rx_byte(8'h11, 1);
    rx_byte(8'h22, 1);
    rx_byte(8'h33, 1);
    rx_byte(8'h44, 1);
    repeat (5) tick();
`ifdef SERIAL_RX_TIMEOUT_EN
    exp_to = 32'h11223344;
`else
    exp_to = 32'hAABB1122;
`endif
    check("timeout_nonce", nonce, exp_to);
    check("model_nonce", nonce, last_nonce);

    repeat (20) tick();
    check("tx_queue_drained", tx_exp.size(), 0);
    check("rx_queue_drained", rx_exp.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
